// File: rtl/load_store_unit_if.sv
// Data-bus interface between the load/store unit (master) and data memory (slave).
// Handshake: a request (read/write enable plus address, byte lanes and data) is held
// stable from its first cycle through the cycle in which bus_ready=1, which completes it.
interface load_store_unit_if;
  logic [31:0] bus_address;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_write_data;
  logic        bus_ready;
  logic [31:0] bus_read_data;

  modport master (
    output bus_address, bus_read_enable, bus_write_enable, bus_byte_enable, bus_write_data,
    input  bus_ready, bus_read_data
  );

  modport slave (
    input  bus_address, bus_read_enable, bus_write_enable, bus_byte_enable, bus_write_data,
    output bus_ready, bus_read_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: converts single-cycle data memory enables into a bus request,
// stalls the core until completion, extends load data, flags misalignment and timeouts.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNTER_WIDTH  = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [2:0]  funct3,
  output logic        stall,
  output logic [31:0] read_data,
  output logic        misaligned_error,
  output logic        bus_error,
  output logic [1:0]  debug_state,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] counter;
  logic [31:0]              req_address;
  logic [2:0]               req_funct3;
  logic [31:0]              req_write_data;
  logic                     req_write;

  logic        access;
  logic        misaligned;
  logic        in_req;
  logic [31:0] read_shifted;
  logic [31:0] load_value;

  assign access      = read_enable | write_enable;
  // funct3[1] set means word (including the undefined encodings); 2'b01 is halfword
  assign misaligned  = (funct3[1] & (address[1:0] != 2'b00)) |
                       ((funct3[1:0] == 2'b01) & address[0]);
  assign in_req      = (state == REQ);
  // Gating with reset lets stall drop as soon as reset asserts, even with enables still high
  assign stall       = reset & (((state == IDLE) & access) | in_req);
  assign debug_state = state;

  assign bus.bus_read_enable  = in_req & ~req_write;
  assign bus.bus_write_enable = in_req & req_write;
  assign bus.bus_address      = {req_address[31:2], 2'b00};

  always_comb begin
    bus.bus_byte_enable = 4'b0000;
    bus.bus_write_data  = req_write_data;
    if (req_funct3[1]) begin
      if (in_req) bus.bus_byte_enable = 4'b1111;
    end else if (req_funct3[0]) begin
      if (in_req) bus.bus_byte_enable = 4'b0011 << {req_address[1], 1'b0};
      bus.bus_write_data = {2{req_write_data[15:0]}};
    end else begin
      if (in_req) bus.bus_byte_enable = 4'b0001 << req_address[1:0];
      bus.bus_write_data = {4{req_write_data[7:0]}};
    end
  end

  // Accesses are aligned here, so shifting by the byte offset lands the lane at bit 0
  assign read_shifted = bus.bus_read_data >> {req_address[1:0], 3'b000};

  always_comb begin
    load_value = read_shifted;
    if (!req_funct3[1]) begin
      if (req_funct3[0])
        load_value = {{16{~req_funct3[2] & read_shifted[15]}}, read_shifted[15:0]};
      else
        load_value = {{24{~req_funct3[2] & read_shifted[7]}}, read_shifted[7:0]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      counter          <= '0;
      req_address      <= '0;
      req_funct3       <= '0;
      req_write_data   <= '0;
      req_write        <= 1'b0;
      read_data        <= '0;
      misaligned_error <= 1'b0;
      bus_error        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (misaligned) begin
              misaligned_error <= 1'b1;
              if (!write_enable) read_data <= '0;
              state <= DONE;
            end else begin
              req_address    <= address;
              req_funct3     <= funct3;
              req_write_data <= write_data;
              req_write      <= write_enable;
              state          <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.bus_ready) begin
            if (!req_write) read_data <= load_value;
            counter <= '0;
            state   <= DONE;
          end else if (counter == LAST_COUNT) begin
            bus_error <= 1'b1;
            read_data <= '0;
            counter   <= '0;
            state     <= DONE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        DONE: begin
          misaligned_error <= 1'b0;
          bus_error        <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases with literal expectations,
// then randomized accesses checked against a byte-level behavioural model.
module tb_load_store_unit;
  localparam int T = 4;

  logic        clock;
  logic        reset;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [2:0]  funct3;
  logic        stall;
  logic [31:0] read_data;
  logic        misaligned_error;
  logic        bus_error;
  logic [1:0]  debug_state;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT_CYCLES(T), .COUNTER_WIDTH(3)) dut (
    .clock            (clock),
    .reset            (reset),
    .read_enable      (read_enable),
    .write_enable     (write_enable),
    .address          (address),
    .write_data       (write_data),
    .funct3           (funct3),
    .stall            (stall),
    .read_data        (read_data),
    .misaligned_error (misaligned_error),
    .bus_error        (bus_error),
    .debug_state      (debug_state),
    .bus              (bus_if.master)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  // per-cycle expectations set by the driver, consumed by the compare process
  logic        chk_en = 1'b0;
  logic        e_stall, e_re, e_we, e_mis, e_berr, e_done, e_load;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  function automatic int size_of(input logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction

  function automatic bit is_aligned(input logic [31:0] a, input logic [2:0] f3);
    return (int'(a[1:0]) % size_of(f3)) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input logic [2:0] f3);
    logic [3:0] be;
    int off, sz;
    off = int'(a[1:0]);
    sz  = size_of(f3);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
    return be;
  endfunction

  function automatic logic [31:0] model_wd(input logic [31:0] wd, input logic [2:0] f3);
    logic [31:0] r;
    int sz;
    sz = size_of(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_ld(input logic [31:0] a, input logic [2:0] f3,
                                           input logic [31:0] rd);
    logic [31:0] v, mask;
    int sz;
    sz = size_of(f3);
    v  = rd >> (8 * int'(a[1:0]));
    if (sz < 4) begin
      mask = 32'hFFFF_FFFF >> (32 - 8 * sz);
      v = v & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // compare process
  always @(negedge clock) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(e_stall));
      check("bus_read_enable", 32'(bus_if.bus_read_enable), 32'(e_re));
      check("bus_write_enable", 32'(bus_if.bus_write_enable), 32'(e_we));
      if (e_re || e_we) begin
        check("bus_byte_enable", 32'(bus_if.bus_byte_enable), 32'(e_be));
        check("bus_address", bus_if.bus_address, e_addr);
        if (e_we) check("bus_write_data", bus_if.bus_write_data, e_wdata);
      end
      check("misaligned_error", 32'(misaligned_error), 32'(e_mis));
      check("bus_error", 32'(bus_error), 32'(e_berr));
      if (e_done && e_load) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL read_data: no expected value queued at %0t", $time);
        end else begin
          check("read_data", read_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic set_idle_exp();
    e_stall = 1'b0; e_re = 1'b0; e_we = 1'b0; e_mis = 1'b0; e_berr = 1'b0;
    e_done = 1'b0; e_load = 1'b0; e_be = 4'b0; e_addr = '0; e_wdata = '0;
  endtask

  task automatic idle_cycles(input int n);
    read_enable = 1'b0; write_enable = 1'b0;
    bus_if.bus_ready = 1'b0;
    set_idle_exp();
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  // driver: called at posedge+1; the core holds the access until the DONE edge
  task automatic do_access(input logic re, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f3, input int delay,
                           input logic [31:0] rd, input logic [3:0] be_x,
                           input logic [31:0] wd_x, input logic [31:0] rd_x);
    bit mis, tmo, is_load;
    int n;
    mis     = !is_aligned(a, f3);
    tmo     = !mis && (delay >= T);
    n       = mis ? 0 : (tmo ? T : delay + 1);
    is_load = re && !we;
    if (is_load) exp_q.push_back((mis || tmo) ? 32'h0 : rd_x);
    read_enable = re; write_enable = we; address = a; write_data = wd; funct3 = f3;
    for (int k = 0; k <= n + 1; k++) begin
      set_idle_exp();
      e_load = is_load;
      if (k >= 1 && k <= n) begin
        bus_if.bus_ready     = (k == delay + 1);
        bus_if.bus_read_data = (k == delay + 1) ? rd : $urandom;
        e_stall = 1'b1; e_re = is_load; e_we = we;
        e_be = be_x; e_addr = {a[31:2], 2'b00}; e_wdata = wd_x;
      end else begin
        bus_if.bus_ready     = 1'($urandom_range(0, 1));
        bus_if.bus_read_data = $urandom;
        if (k == 0) e_stall = 1'b1;
        else begin
          e_done = 1'b1; e_mis = mis; e_berr = tmo;
        end
      end
      @(posedge clock); #1;
    end
    idle_cycles(0);
  endtask

  task automatic rand_access();
    logic re, we;
    logic [31:0] a, wd, rd;
    logic [2:0] f3;
    int sel, delay;
    sel = $urandom_range(0, 2);
    re  = (sel != 1);
    we  = (sel != 0);
    a   = $urandom;
    wd  = $urandom;
    rd  = $urandom;
    f3  = 3'($urandom_range(0, 7));
    // keep misaligned cases present but not dominant
    if ($urandom_range(0, 3) != 0) a[1:0] = a[1:0] & ~(2'(size_of(f3) - 1));
    delay = $urandom_range(0, T + 1);
    do_access(re, we, a, wd, f3, delay, rd, model_be(a, f3), model_wd(wd, f3),
              model_ld(a, f3, rd));
  endtask

  initial begin
    reset = 1'b0;
    read_enable = 1'b0; write_enable = 1'b0; address = '0; write_data = '0; funct3 = '0;
    bus_if.bus_ready = 1'b0; bus_if.bus_read_data = '0;
    set_idle_exp();
    repeat (3) @(posedge clock);
    #1;
    check("reset stall", 32'(stall), 32'h0);
    check("reset read_data", read_data, 32'h0);
    check("reset misaligned_error", 32'(misaligned_error), 32'h0);
    check("reset bus_error", 32'(bus_error), 32'h0);
    check("reset bus_read_enable", 32'(bus_if.bus_read_enable), 32'h0);
    check("reset bus_write_enable", 32'(bus_if.bus_write_enable), 32'h0);
    check("reset state", 32'(debug_state), 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk_en = 1'b1;

    // directed cases with hand-computed expectations
    do_access(1, 0, 32'h100, 32'h0, 3'b010, 0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
    do_access(1, 0, 32'h103, 32'h0, 3'b000, 1, 32'h80112233, 4'b1000, 32'h0, 32'hFFFFFF80);
    do_access(1, 0, 32'h103, 32'h0, 3'b100, 0, 32'h80112233, 4'b1000, 32'h0, 32'h00000080);
    do_access(0, 1, 32'h202, 32'h0000ABCD, 3'b001, 2, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0);
    do_access(1, 0, 32'h101, 32'h0, 3'b010, 0, 32'h0, 4'b0000, 32'h0, 32'h0);
    do_access(1, 0, 32'h400, 32'h0, 3'b010, 10, 32'h55555555, 4'b1111, 32'h0, 32'h0);
    do_access(1, 1, 32'h506, 32'h1234_5678, 3'b001, 1, 32'h0, 4'b1100, 32'h56785678, 32'h0);
    do_access(1, 0, 32'h502, 32'h0, 3'b101, 0, 32'h8001_7FFF, 4'b1100, 32'h0, 32'h00008001);
    idle_cycles(2);

    // reset during a pending request
    chk_en = 1'b0;
    read_enable = 1'b1; address = 32'h300; funct3 = 3'b010;
    repeat (3) @(posedge clock);
    #1;
    check("pre-reset bus_read_enable", 32'(bus_if.bus_read_enable), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check("async reset stall", 32'(stall), 32'h0);
    check("async reset bus_read_enable", 32'(bus_if.bus_read_enable), 32'h0);
    check("async reset bus_write_enable", 32'(bus_if.bus_write_enable), 32'h0);
    check("async reset state", 32'(debug_state), 32'h0);
    read_enable = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    set_idle_exp();
    chk_en = 1'b1;
    do_access(1, 0, 32'h104, 32'h0, 3'b010, 1, 32'h12345678, 4'b1111, 32'h0, 32'h12345678);

    // randomized accesses against the model
    for (int i = 0; i < 200; i++) begin
      rand_access();
      idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(2);
    chk_en = 1'b0;

    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL leftover: %0d expected loads never completed", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
